// File: rtl/uart_pkg.sv
// Shared types, CSR bit positions and baud helper for the UART transmitter.
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_tx_state_e;

  localparam int CSR_BUSY_BIT  = 0;
  localparam int CSR_FULL_BIT  = 1;
  localparam int CSR_EMPTY_BIT = 2;
  localparam int CSR_OVF_BIT   = 3;
  localparam int CSR_LEVEL_LSB = 4;

  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous FIFO with first-word fall-through output; push while full
// is accepted when a pop happens in the same cycle.
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      if (do_push && !do_pop)      level <= level + LW'(1);
      else if (do_pop && !do_push) level <= level - LW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_tx_core.sv
// Memory-mapped 8N1 UART transmitter with TX FIFO and 32-bit status CSR.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1 frame).
module uart_tx_core
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 12_000_000,
  parameter int BAUD       = 115_200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [7:0]  wr_data,
  input  logic        clr_ovf,
  output logic        tx_ready,
  output logic [31:0] csr,
  output logic        usb_tx
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int LW           = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(CLKS_PER_BIT - 1);

  if (CLKS_PER_BIT < 2) begin : g_bad_baud
    $error("uart_tx_core: CLK_HZ/BAUD must be at least 2");
  end
  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 8 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_core: FIFO_DEPTH must be a power of two in 2..8");
  end

  uart_tx_state_e   state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [2:0]       bit_idx, bit_next;
  logic [7:0]       shift, shift_next;
  logic             tx_next;
  logic             ovf;
  logic             pop;
  logic             bit_end;
  logic [7:0]       fifo_dout;
  logic             fifo_full;
  logic             fifo_empty;
  logic [LW-1:0]    fifo_level;
`ifdef UART_TX_PARITY_EN
  logic             par, par_next;
`endif

  uart_tx_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wr_en),
    .pop   (pop),
    .din   (wr_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign bit_end = (cnt == '0);

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    bit_next   = bit_idx;
    shift_next = shift;
    tx_next    = 1'b1;
    pop        = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_next   = par;
`endif
    case (state)
      IDLE:  pop = !fifo_empty;
      START: if (bit_end) begin
        state_next = DATA;
        bit_next   = '0;
      end
      DATA: if (bit_end) begin
        if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
          state_next = PARITY;
`else
          state_next = STOP;
`endif
        end else begin
          bit_next   = bit_idx + 3'd1;
          shift_next = {1'b0, shift[7:1]};
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (bit_end) state_next = STOP;
`endif
      STOP: if (bit_end) begin
        if (!fifo_empty) pop = 1'b1;
        else             state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    // A pop (from IDLE or the last STOP cycle) always starts a fresh frame.
    if (pop) begin
      state_next = START;
      shift_next = fifo_dout;
`ifdef UART_TX_PARITY_EN
      par_next   = ^fifo_dout;
`endif
    end

    if (pop || (bit_end && state != IDLE)) cnt_next = CNT_RELOAD;
    else if (state != IDLE)                cnt_next = cnt - CNT_W'(1);

    // Line level follows the next state so usb_tx is a plain flop.
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_next = par_next;
`endif
      default: tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
      usb_tx  <= 1'b1;
      ovf     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par     <= 1'b0;
`endif
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      bit_idx <= bit_next;
      shift   <= shift_next;
      usb_tx  <= tx_next;
`ifdef UART_TX_PARITY_EN
      par     <= par_next;
`endif
      if (wr_en && fifo_full && !pop) ovf <= 1'b1;
      else if (clr_ovf)               ovf <= 1'b0;
    end
  end

  assign tx_ready = !fifo_full;

  always_comb begin
    csr                         = '0;
    csr[CSR_BUSY_BIT]           = (state != IDLE);
    csr[CSR_FULL_BIT]           = fifo_full;
    csr[CSR_EMPTY_BIT]          = fifo_empty;
    csr[CSR_OVF_BIT]            = ovf;
    csr[CSR_LEVEL_LSB +: 4]     = 4'(fifo_level);
  end

endmodule

// File: tb/tb_uart_tx_core.sv
// Scoreboard bench for uart_tx_core: a timeline model predicts accepted bytes,
// frame start cycles and CSR contents; a line monitor decodes usb_tx frames.
module tb_uart_tx_core;

  localparam int CLK_HZ = 1_000_000;
  localparam int BAUD   = 250_000;
  localparam int DEPTH  = 4;
  localparam int CPB    = CLK_HZ / BAUD;
`ifdef UART_TX_PARITY_EN
  localparam int NB     = 11;
`else
  localparam int NB     = 10;
`endif
  localparam int FRAME  = NB * CPB;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [7:0]  wr_data;
  logic        clr_ovf;
  logic        tx_ready;
  logic [31:0] csr;
  logic        usb_tx;

  uart_tx_core #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .FIFO_DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .clr_ovf  (clr_ovf),
    .tx_ready (tx_ready),
    .csr      (csr),
    .usb_tx   (usb_tx)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] data;
    int         start;
  } frame_t;

  frame_t exp_q[$];
  int     wq[$];
  int     pq[$];
  logic   model_ovf;
  int     n_checks = 0;
  int     n_fail   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Timeline model: a byte written in cycle W sits in the FIFO from W+1 until its
  // pop cycle P; its frame occupies the line in cycles P+1 .. P+FRAME.
  function automatic int fifo_count(input int c);
    int n = 0;
    foreach (wq[i]) if (wq[i] < c && pq[i] >= c) n++;
    return n;
  endfunction

  function automatic bit pop_at(input int c);
    foreach (pq[i]) if (pq[i] == c && wq[i] < c) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit busy_at(input int c);
    foreach (pq[i]) if (c >= pq[i] + 1 && c <= pq[i] + FRAME) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_csr(input int c);
    int          lvl = fifo_count(c);
    logic [31:0] r   = '0;
    r[0]   = busy_at(c);
    r[1]   = (lvl == DEPTH);
    r[2]   = (lvl == 0);
    r[3]   = model_ovf;
    r[7:4] = 4'(lvl);
    return r;
  endfunction

  task automatic model_step(input int n, input bit wr, input logic [7:0] b, input bit clr);
    bit     drop;
    int     p;
    frame_t fr;
    drop = 1'b0;
    if (wr) begin
      if (fifo_count(n) < DEPTH || pop_at(n)) begin
        p = n + 1;
        if (pq.size() > 0 && pq[$] + FRAME > p) p = pq[$] + FRAME;
        wq.push_back(n);
        pq.push_back(p);
        fr.data  = b;
        fr.start = p + 1;
        exp_q.push_back(fr);
      end else begin
        drop = 1'b1;
      end
    end
    if (drop)     model_ovf = 1'b1;
    else if (clr) model_ovf = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  task automatic send(input logic [7:0] b, input bit clr);
    model_step(cyc, 1'b1, b, clr);
    wr_en   = 1'b1;
    wr_data = b;
    clr_ovf = clr;
    tick();
    wr_en   = 1'b0;
    clr_ovf = 1'b0;
  endtask

  task automatic idle(input bit clr);
    model_step(cyc, 1'b0, 8'h00, clr);
    clr_ovf = clr;
    tick();
    clr_ovf = 1'b0;
  endtask

  task automatic model_reset();
    wq.delete();
    pq.delete();
    exp_q.delete();
    model_ovf = 1'b0;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b0;
    model_reset();
    repeat (n) tick();
    rst = 1'b1;
  endtask

  task automatic check_model(input string name);
    check(name, csr, model_csr(cyc));
    check({name, "_ready"}, 32'(tx_ready), 32'(fifo_count(cyc) < DEPTH));
  endtask

  task automatic drain();
    if (pq.size() > 0) wait_until(pq[$] + FRAME + 1);
  endtask

  task automatic check_frame(input int start_c, input logic [NB-1:0] s);
    frame_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL frame_unexpected: got byte %h starting cycle %0d, required no frame", s[8:1], start_c);
    end else begin
      e = exp_q.pop_front();
      check("frame_data", 32'(s[8:1]), 32'(e.data));
      check("frame_start_cycle", 32'(start_c), 32'(e.start));
      check("start_bit", 32'(s[0]), 32'(0));
      check("stop_bit", 32'(s[NB-1]), 32'(1));
`ifdef UART_TX_PARITY_EN
      check("parity_bit", 32'(s[9]), 32'($countones(e.data) % 2));
`endif
    end
  endtask

  // Line receiver: detects a falling edge and samples each bit mid-cell.
  task automatic monitor();
    bit              in_frame = 1'b0;
    logic            prev     = 1'b1;
    int              start_c  = 0;
    int              off;
    int              k;
    logic [NB-1:0]   s        = '1;
    forever begin
      @(negedge clk);
      if (rst !== 1'b1) begin
        in_frame = 1'b0;
        prev     = 1'b1;
      end else begin
        if (!in_frame) begin
          if (prev === 1'b1 && usb_tx === 1'b0) begin
            in_frame = 1'b1;
            start_c  = cyc;
            s        = '1;
          end
        end else begin
          off = cyc - start_c;
          if (off % CPB == CPB / 2) begin
            k    = off / CPB;
            s[k] = usb_tx;
            if (k == NB - 1) begin
              in_frame = 1'b0;
              check_frame(start_c, s);
            end
          end
        end
        prev = usb_tx;
      end
    end
  endtask

  initial begin
    int n;
    rst       = 1'b0;
    wr_en     = 1'b0;
    wr_data   = '0;
    clr_ovf   = 1'b0;
    model_ovf = 1'b0;
    fork
      monitor();
    join_none

    // Reset and idle line
    do_reset(3);
    check("rst_csr", csr, 32'h4);
    check("rst_ready", 32'(tx_ready), 32'(1));
    check("rst_tx", 32'(usb_tx), 32'(1));
    repeat (12) begin
      idle(1'b0);
      check("idle_line", 32'(usb_tx), 32'(1));
    end
    check_model("idle_csr");

    // Single byte: latency and frame length
    n = cyc;
    send(8'h55, 1'b0);
    check("lat_n1_high", 32'(usb_tx), 32'(1));
    tick();
    check("lat_n2_low", 32'(usb_tx), 32'(0));
    wait_until(n + 41);
    check("busy_last_stop", 32'(csr[0]), 32'(1));
    tick();
    check("single_done_csr", csr, 32'h4);

    // Four back-to-back frames
    n = cyc;
    for (int i = 1; i <= 4; i++) send(8'(i), 1'b0);
    check_model("b2b_csr");
    wait_until(n + 161);
    check("b2b_busy_end", 32'(csr[0]), 32'(1));
    tick();
    check("b2b_done_csr", csr, 32'h4);

    // Overflow, clear priority, write-while-full with pop
    n = cyc;
    for (int i = 0; i < 6; i++) send(8'h10 + 8'(i), 1'b0);
    check("ovf_flag", 32'(csr[3]), 32'(1));
    check("ovf_level", 32'(csr[7:4]), 32'(4));
    check("ovf_ready", 32'(tx_ready), 32'(0));
    check_model("ovf_csr");
    send(8'hEE, 1'b1);
    check("ovf_set_wins", 32'(csr[3]), 32'(1));
    idle(1'b1);
    check("ovf_cleared", 32'(csr[3]), 32'(0));
    wait_until(n + 41);
    check("full_before_pop", 32'(tx_ready), 32'(0));
    send(8'h77, 1'b0);
    check("full_push_pop_ovf", 32'(csr[3]), 32'(0));
    check("full_push_pop_level", 32'(csr[7:4]), 32'(4));
    check_model("full_push_pop_csr");
    drain();
    check("ovf_drain_csr", csr, 32'h4);

    // Reset mid-frame
    n = cyc;
    send(8'hA5, 1'b0);
    wait_until(n + 19);
    check("mid_bit3", 32'(usb_tx), 32'(0));
    rst = 1'b0;
    model_reset();
    tick();
    check("midrst_tx", 32'(usb_tx), 32'(1));
    check("midrst_csr", csr, 32'h4);
    tick();
    rst = 1'b1;
    tick();
    send(8'h3C, 1'b0);
    drain();
    check("post_rst_csr", csr, 32'h4);

`ifdef UART_TX_PARITY_EN
    // Parity bit values
    n = cyc;
    send(8'h07, 1'b0);
    wait_until(n + 39);
    check("parity_07", 32'(usb_tx), 32'(1));
    wait_until(n + 45);
    check("par_busy_end", 32'(csr[0]), 32'(1));
    tick();
    check("par_done_csr", csr, 32'h4);
    n = cyc;
    send(8'h03, 1'b0);
    wait_until(n + 39);
    check("parity_03", 32'(usb_tx), 32'(0));
    drain();
`endif

    // Randomized traffic: dense bursts, then sparse writes
    for (int i = 0; i < 900; i++) begin
      bit         w;
      bit         c;
      logic [7:0] b;
      w = (i < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 50) == 0);
      c = ($urandom_range(0, 15) == 0);
      b = 8'($urandom);
      if (w) send(b, c);
      else   idle(c);
      check_model("rand_csr");
    end
    drain();
    check_model("rand_drain_csr");

    for (int i = 0; i < 100 && exp_q.size() != 0; i++) tick();
    check("scoreboard_empty", 32'(exp_q.size()), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
